// File: rtl/tt_debug_sequencer.sv
// tt_debug_sequencer
// Byte-command controller that drives reset, clock-enable and ui_in of the
// TinyTapeout user module and reads back its outputs on request.
//
// Ports:
//   clk, rst_n                 system clock, async active-low reset
//   rx_data/rx_valid/rx_ready  command/argument byte input
//   tx_data/tx_valid/tx_ready  reply byte output (valid/ready handshake)
//   err_overrun                sticky: a byte arrived while rx_ready was low
//   dut_rst_n, dut_ena         reset and clock-enable to the user module
//   dut_ui_in                  user module input bus
//   dut_uo_out, dut_uio_out,
//   dut_uio_oe                 user module outputs, sampled by 'O'
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a command byte
// ARG      | waiting for the argument byte of 'I' or 'S'
// RESET    | holding dut_rst_n low with dut_ena high
// STEP     | pulsing dut_ena for the requested number of cycles
// REPLY    | presenting reply bytes until each one transfers

module tt_debug_sequencer #(
    parameter int RESET_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       err_overrun,
    output logic       dut_rst_n,
    output logic       dut_ena,
    output logic [7:0] dut_ui_in,
    input  logic [7:0] dut_uo_out,
    input  logic [7:0] dut_uio_out,
    input  logic [7:0] dut_uio_oe
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARG   = 3'd1;
    localparam logic [2:0] ST_RESET = 3'd2;
    localparam logic [2:0] ST_STEP  = 3'd3;
    localparam logic [2:0] ST_REPLY = 3'd4;

    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_I = 8'h49;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_G = 8'h47;
    localparam logic [7:0] CMD_H = 8'h48;
    localparam logic [7:0] CMD_O = 8'h4F;
    localparam logic [7:0] REP_OK  = 8'h2E;
    localparam logic [7:0] REP_BAD = 8'h3F;

    localparam logic [8:0] RST_LOAD = 9'(RESET_CYCLES);

    logic [2:0] state;
    logic       arg_is_step;
    logic       run_flag;
    logic [8:0] cnt;
    logic [7:0] rep0, rep1, rep2;
    logic [1:0] rep_left;
    logic [7:0] ui_in_r;
    logic       rst_out_r;
    logic       overrun_r;

    assign rx_ready    = (state == ST_IDLE) || (state == ST_ARG);
    assign tx_valid    = (state == ST_REPLY);
    assign tx_data     = rep0;
    assign err_overrun = overrun_r;
    assign dut_rst_n   = rst_out_r;
    assign dut_ui_in   = ui_in_r;
    assign dut_ena     = run_flag || (state == ST_RESET) || (state == ST_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            arg_is_step <= 1'b0;
            run_flag    <= 1'b0;
            cnt         <= 9'd0;
            rep0        <= 8'h00;
            rep1        <= 8'h00;
            rep2        <= 8'h00;
            rep_left    <= 2'd0;
            ui_in_r     <= 8'h00;
            rst_out_r   <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            if (rx_valid && !rx_ready) begin
                overrun_r <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        rep_left <= 2'd1;
                        case (rx_data)
                            CMD_R: begin
                                run_flag  <= 1'b0;
                                rst_out_r <= 1'b0;
                                cnt       <= RST_LOAD;
                                state     <= ST_RESET;
                            end
                            CMD_I: begin
                                arg_is_step <= 1'b0;
                                state       <= ST_ARG;
                            end
                            CMD_S: begin
                                arg_is_step <= 1'b1;
                                state       <= ST_ARG;
                            end
                            CMD_G: begin
                                run_flag <= 1'b1;
                                rep0     <= REP_OK;
                                state    <= ST_REPLY;
                            end
                            CMD_H: begin
                                run_flag <= 1'b0;
                                rep0     <= REP_OK;
                                state    <= ST_REPLY;
                            end
                            CMD_O: begin
                                rep0     <= dut_uo_out;
                                rep1     <= dut_uio_out;
                                rep2     <= dut_uio_oe;
                                rep_left <= 2'd3;
                                state    <= ST_REPLY;
                            end
                            default: begin
                                rep0  <= REP_BAD;
                                state <= ST_REPLY;
                            end
                        endcase
                    end
                end

                ST_ARG: begin
                    if (rx_valid) begin
                        if (arg_is_step) begin
                            // an argument of zero means a full 256-cycle step
                            run_flag <= 1'b0;
                            cnt      <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                            state    <= ST_STEP;
                        end else begin
                            ui_in_r  <= rx_data;
                            rep0     <= REP_OK;
                            rep_left <= 2'd1;
                            state    <= ST_REPLY;
                        end
                    end
                end

                // counter holds the cycles remaining including the current one
                ST_RESET: begin
                    if (cnt == 9'd1) begin
                        rst_out_r <= 1'b1;
                        rep0      <= REP_OK;
                        rep_left  <= 2'd1;
                        state     <= ST_REPLY;
                    end else begin
                        cnt <= cnt - 9'd1;
                    end
                end

                ST_STEP: begin
                    if (cnt == 9'd1) begin
                        rep0     <= REP_OK;
                        rep_left <= 2'd1;
                        state    <= ST_REPLY;
                    end else begin
                        cnt <= cnt - 9'd1;
                    end
                end

                ST_REPLY: begin
                    if (tx_ready) begin
                        rep0     <= rep1;
                        rep1     <= rep2;
                        rep_left <= rep_left - 2'd1;
                        if (rep_left == 2'd1) begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_debug_sequencer.sv
module tb_tt_debug_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       err_overrun;
    logic       dut_rst_n;
    logic       dut_ena;
    logic [7:0] dut_ui_in;
    logic [7:0] dut_uo_out = 8'h00;
    logic [7:0] dut_uio_out = 8'h00;
    logic [7:0] dut_uio_oe = 8'h00;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tt_debug_sequencer #(.RESET_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .err_overrun (err_overrun),
        .dut_rst_n   (dut_rst_n),
        .dut_ena     (dut_ena),
        .dut_ui_in   (dut_ui_in),
        .dut_uo_out  (dut_uo_out),
        .dut_uio_out (dut_uio_out),
        .dut_uio_oe  (dut_uio_oe)
    );

    // Presents one byte for one cycle; returns at the negedge after the
    // accepting posedge, i.e. observing cycle T+1.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (dut_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_dut_rst_n got %b want 0", dut_rst_n); end
        n_checks++; if (dut_ena !== 1'b0) begin n_fail++; $display("FAIL reset_dut_ena got %b want 0", dut_ena); end
        n_checks++; if (dut_ui_in !== 8'h00) begin n_fail++; $display("FAIL reset_ui_in got %h want 00", dut_ui_in); end
        n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx got v=%b d=%h want v=0 d=00", tx_valid, tx_data); end
        n_checks++; if (rx_ready !== 1'b1 || err_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_rx got rdy=%b ovr=%b want 1 0", rx_ready, err_overrun); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (dut_rst_n !== 1'b0) begin n_fail++; $display("FAIL idle_dut_rst_n got %b want 0", dut_rst_n); end
    endtask

    task automatic test_r_cmd();
        int low = 0;
        bit bad_ena = 0;
        send(8'h52);
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL r_rx_ready got %b want 0", rx_ready); end
        while (dut_rst_n === 1'b0 && low < 100) begin
            if (dut_ena !== 1'b1) bad_ena = 1;
            low++;
            @(negedge clk);
        end
        n_checks++; if (low != 16) begin n_fail++; $display("FAIL r_low_cycles got %0d want 16", low); end
        n_checks++; if (bad_ena) begin n_fail++; $display("FAIL r_ena_during_reset got low want high"); end
        n_checks++; if (dut_ena !== 1'b0) begin n_fail++; $display("FAIL r_ena_after got %b want 0", dut_ena); end
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h2E) begin n_fail++; $display("FAIL r_reply got v=%b d=%h want 1 2e", tx_valid, tx_data); end
        @(negedge clk);
        n_checks++; if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL r_done got rdy=%b v=%b want 1 0", rx_ready, tx_valid); end
    endtask

    task automatic test_step(input logic [7:0] n, input int want);
        int hi = 0;
        send(8'h53);
        n_checks++; if (rx_ready !== 1'b1 || dut_ena !== 1'b0) begin n_fail++; $display("FAIL step_arg_wait n=%0d got rdy=%b ena=%b want 1 0", want, rx_ready, dut_ena); end
        send(n);
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL step_rx_ready n=%0d got %b want 0", want, rx_ready); end
        while (dut_ena === 1'b1 && hi < 400) begin
            hi++;
            @(negedge clk);
        end
        n_checks++; if (hi != want) begin n_fail++; $display("FAIL step_ena_cycles got %0d want %0d", hi, want); end
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h2E) begin n_fail++; $display("FAIL step_reply n=%0d got v=%b d=%h want 1 2e", want, tx_valid, tx_data); end
        @(negedge clk);
    endtask

    task automatic test_io();
        send(8'h49);
        send(8'hA5);
        n_checks++; if (dut_ui_in !== 8'hA5) begin n_fail++; $display("FAIL io_ui_in got %h want a5", dut_ui_in); end
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h2E) begin n_fail++; $display("FAIL io_i_reply got v=%b d=%h want 1 2e", tx_valid, tx_data); end
        @(negedge clk);
        dut_uo_out  = 8'h12;
        dut_uio_out = 8'h34;
        dut_uio_oe  = 8'h56;
        send(8'h4F);
        // change inputs after acceptance; the reply must use the snapshot
        dut_uo_out  = 8'hFF;
        dut_uio_out = 8'hFF;
        dut_uio_oe  = 8'hFF;
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h12) begin n_fail++; $display("FAIL io_o_byte0 got v=%b d=%h want 1 12", tx_valid, tx_data); end
        n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL io_o_rx_ready got %b want 0", rx_ready); end
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h34) begin n_fail++; $display("FAIL io_o_byte1 got v=%b d=%h want 1 34", tx_valid, tx_data); end
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h34) begin n_fail++; $display("FAIL io_o_hold%0d got v=%b d=%h want 1 34", i, tx_valid, tx_data); end
        end
        tx_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h56) begin n_fail++; $display("FAIL io_o_byte2 got v=%b d=%h want 1 56", tx_valid, tx_data); end
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin n_fail++; $display("FAIL io_o_done got v=%b rdy=%b want 0 1", tx_valid, rx_ready); end
    endtask

    task automatic test_run();
        int hi = 0;
        send(8'h47);
        n_checks++; if (dut_ena !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h2E) begin n_fail++; $display("FAIL run_g got ena=%b v=%b d=%h want 1 1 2e", dut_ena, tx_valid, tx_data); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (dut_ena !== 1'b1) begin n_fail++; $display("FAIL run_hold%0d got %b want 1", i, dut_ena); end
        end
        send(8'h48);
        n_checks++; if (dut_ena !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h2E) begin n_fail++; $display("FAIL run_h got ena=%b v=%b d=%h want 0 1 2e", dut_ena, tx_valid, tx_data); end
        @(negedge clk);
        send(8'h47);
        @(negedge clk);
        send(8'h53);
        n_checks++; if (dut_ena !== 1'b1) begin n_fail++; $display("FAIL run_s_arg_ena got %b want 1", dut_ena); end
        send(8'h02);
        while (dut_ena === 1'b1 && hi < 400) begin
            hi++;
            @(negedge clk);
        end
        n_checks++; if (hi != 2) begin n_fail++; $display("FAIL run_step_cycles got %0d want 2", hi); end
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h2E) begin n_fail++; $display("FAIL run_step_reply got v=%b d=%h want 1 2e", tx_valid, tx_data); end
        @(negedge clk);
        n_checks++; if (dut_ena !== 1'b0) begin n_fail++; $display("FAIL run_cleared got %b want 0", dut_ena); end
    endtask

    task automatic test_misc();
        int wait_cnt = 0;
        send(8'h7A);
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h3F) begin n_fail++; $display("FAIL unknown_reply got v=%b d=%h want 1 3f", tx_valid, tx_data); end
        @(negedge clk);
        n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_pre got %b want 0", err_overrun); end
        send(8'h53);
        send(8'h10);
        send(8'h47);
        n_checks++; if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set got %b want 1", err_overrun); end
        while (tx_valid !== 1'b1 && wait_cnt < 100) begin
            wait_cnt++;
            @(negedge clk);
        end
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h2E) begin n_fail++; $display("FAIL overrun_step_reply got v=%b d=%h want 1 2e", tx_valid, tx_data); end
        @(negedge clk);
        n_checks++; if (dut_ena !== 1'b0 || err_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_dropped got ena=%b ovr=%b want 0 1", dut_ena, err_overrun); end
        send(8'h49);
        send(8'h52);
        n_checks++; if (dut_ui_in !== 8'h52 || dut_rst_n !== 1'b1 || dut_ena !== 1'b0) begin n_fail++; $display("FAIL arg_r got ui=%h rst=%b ena=%b want 52 1 0", dut_ui_in, dut_rst_n, dut_ena); end
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h2E) begin n_fail++; $display("FAIL arg_r_reply got v=%b d=%h want 1 2e", tx_valid, tx_data); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        send(8'h52);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (dut_rst_n !== 1'b0 || dut_ena !== 1'b0 || dut_ui_in !== 8'h00) begin n_fail++; $display("FAIL arst_r_dut got rst=%b ena=%b ui=%h want 0 0 00", dut_rst_n, dut_ena, dut_ui_in); end
        n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || rx_ready !== 1'b1 || err_overrun !== 1'b0) begin n_fail++; $display("FAIL arst_r_if got v=%b d=%h rdy=%b ovr=%b want 0 00 1 0", tx_valid, tx_data, rx_ready, err_overrun); end
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h49);
        send(8'h33);
        @(negedge clk);
        send(8'h53);
        send(8'h00);
        repeat (100) @(negedge clk);
        n_checks++; if (dut_ena !== 1'b1) begin n_fail++; $display("FAIL arst_s_running got %b want 1", dut_ena); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (dut_ena !== 1'b0 || dut_ui_in !== 8'h00 || dut_rst_n !== 1'b0) begin n_fail++; $display("FAIL arst_s_dut got ena=%b ui=%h rst=%b want 0 00 0", dut_ena, dut_ui_in, dut_rst_n); end
        n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || rx_ready !== 1'b1) begin n_fail++; $display("FAIL arst_s_if got v=%b d=%h rdy=%b want 0 00 1", tx_valid, tx_data, rx_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (dut_ena !== 1'b0 || rx_ready !== 1'b1) begin n_fail++; $display("FAIL arst_s_after got ena=%b rdy=%b want 0 1", dut_ena, rx_ready); end
    endtask

    initial begin
        test_reset();
        test_r_cmd();
        test_step(8'h03, 3);
        test_step(8'h00, 256);
        test_io();
        test_run();
        test_misc();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
